// File: rtl/l2_cache_assoc_control.sv
// l2_cache_assoc_control: control FSM for an N-way set-associative, write-back,
// write-allocate L2 cache. Owns per-set tree pseudo-LRU state and victim selection;
// tag compare and the tag/data/valid/dirty arrays live in the datapath.
// Optional build macro L2_PERF_CNT_EN adds saturating hit/miss/write-back counters.
module l2_cache_assoc_control #(
   parameter int unsigned WAYS = 4,
   parameter int unsigned SETS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_read,
   input  logic                     mem_write,
   output logic                     mem_resp,
   input  logic [$clog2(SETS)-1:0]  set_idx,
   input  logic [WAYS-1:0]          hit_vec,
   input  logic [WAYS-1:0]          valid_vec,
   input  logic [WAYS-1:0]          dirty_vec,
   input  logic                     pmem_resp,
   output logic                     pmem_read,
   output logic                     pmem_write,
   output logic [WAYS-1:0]          way_sel,
   output logic                     data_write,
   output logic                     tag_write,
   output logic                     valid_in,
   output logic                     dirty_in,
   output logic                     data_in_sel,
   output logic                     pmem_addr_sel
`ifdef L2_PERF_CNT_EN
   ,
   output logic [31:0]              hit_cnt,
   output logic [31:0]              miss_cnt,
   output logic [31:0]              wb_cnt
`endif
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned NODES = WAYS - 1;

   typedef enum logic [1:0] {IDLE, WRITE_BACK, FILL} state_e;

   state_e            state_q, state_d;
   logic [WAY_W-1:0]  victim_q, victim_d;
   logic [NODES-1:0]  plru_q [SETS];
   logic              plru_upd;
   logic [WAY_W-1:0]  plru_way;
   logic              req;
   logic [WAY_W-1:0]  hit_way, inv_way, miss_way;
   logic              any_inv;
   logic [IDX_W-1:0]  set_w;

   assign req   = mem_read | mem_write;
   assign set_w = set_idx;

   // Walk the tree from the root following each node's victim pointer (0 = left).
   function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
      int unsigned n;
      logic        b;
      n = 0;
      for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
         b = 1'b0;
         for (int unsigned k = 0; k < NODES; k++)
            if (k == n) b = bits[k];
         n = b ? (2 * n + 2) : (2 * n + 1);
      end
      return WAY_W'(n - NODES);
   endfunction

   // Climb from the accessed leaf to the root, pointing every node away from it.
   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
      logic [NODES-1:0] r;
      int unsigned      c, p;
      r = bits;
      c = 32'(way) + NODES;
      for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
         p = (c - 1) / 2;
         for (int unsigned k = 0; k < NODES; k++)
            if (k == p) r[k] = c[0];
         c = p;
      end
      return r;
   endfunction

   // Encode hit way and pick the miss victim (lowest invalid way, else PLRU).
   always_comb begin
      hit_way = '0;
      inv_way = '0;
      any_inv = 1'b0;
      for (int unsigned k = WAYS; k > 0; k--) begin
         if (hit_vec[k-1]) hit_way = WAY_W'(k - 1);
         if (!valid_vec[k-1]) begin
            inv_way = WAY_W'(k - 1);
            any_inv = 1'b1;
         end
      end
      miss_way = any_inv ? inv_way : plru_victim(plru_q[set_w]);
   end

   // Next-state and output decode; every output forced low while reset is asserted.
   always_comb begin
      state_d       = state_q;
      victim_d      = victim_q;
      plru_upd      = 1'b0;
      plru_way      = victim_q;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      way_sel       = '0;
      data_write    = 1'b0;
      tag_write     = 1'b0;
      valid_in      = 1'b0;
      dirty_in      = 1'b0;
      data_in_sel   = 1'b0;
      pmem_addr_sel = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (|hit_vec) begin
                  mem_resp = 1'b1;
                  way_sel  = hit_vec;
                  plru_upd = 1'b1;
                  plru_way = hit_way;
                  if (mem_write) begin
                     data_write = 1'b1;
                     dirty_in   = 1'b1;
                  end
               end else begin
                  victim_d = miss_way;
                  state_d  = (valid_vec[miss_way] & dirty_vec[miss_way]) ? WRITE_BACK : FILL;
               end
            end
         end
         WRITE_BACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            way_sel       = WAYS'(1) << victim_q;
            if (pmem_resp) state_d = FILL;
         end
         FILL: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               way_sel     = WAYS'(1) << victim_q;
               data_write  = 1'b1;
               tag_write   = 1'b1;
               valid_in    = 1'b1;
               data_in_sel = 1'b1;
               plru_upd    = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         plru_upd      = 1'b0;
         mem_resp      = 1'b0;
         pmem_read     = 1'b0;
         pmem_write    = 1'b0;
         way_sel       = '0;
         data_write    = 1'b0;
         tag_write     = 1'b0;
         valid_in      = 1'b0;
         dirty_in      = 1'b0;
         data_in_sel   = 1'b0;
         pmem_addr_sel = 1'b0;
      end
   end

   // State and latched victim registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         victim_q <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
      end
   end

   // Per-set PLRU tree bits, updated on hit and on fill completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (plru_upd) begin
         plru_q[set_w] <= plru_touch(plru_q[set_w], plru_way);
      end
   end

`ifdef L2_PERF_CNT_EN
   logic        hit_ev, miss_ev, wb_ev;
   logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

   assign hit_ev   = (state_q == IDLE) & req & (|hit_vec);
   assign miss_ev  = (state_q == IDLE) & req & ~(|hit_vec);
   assign wb_ev    = (state_q == WRITE_BACK) & pmem_resp;
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
   assign wb_cnt   = wb_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         if (hit_ev  && hit_cnt_q  != '1) hit_cnt_q  <= hit_cnt_q  + 32'd1;
         if (miss_ev && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
         if (wb_ev   && wb_cnt_q   != '1) wb_cnt_q   <= wb_cnt_q   + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_cache_assoc_control.sv
// Bench for l2_cache_assoc_control: the bench acts as the L2 datapath (tag/valid/dirty
// arrays) and physical memory, and predicts controller outputs from a cache model.
module tb_l2_cache_assoc_control;
   localparam int WAYS  = 4;
   localparam int SETS  = 8;
   localparam int IDX_W = 3;
   localparam int OW    = 9 + WAYS;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             mem_read = 1'b0, mem_write = 1'b0, mem_resp;
   logic [IDX_W-1:0] set_idx = '0;
   logic [WAYS-1:0]  hit_vec = '0, valid_vec = '0, dirty_vec = '0;
   logic             pmem_resp = 1'b0, pmem_read, pmem_write;
   logic [WAYS-1:0]  way_sel;
   logic             data_write, tag_write, valid_in, dirty_in, data_in_sel, pmem_addr_sel;
`ifdef L2_PERF_CNT_EN
   logic [31:0]      hit_cnt, miss_cnt, wb_cnt;
`endif

   int tests = 0;
   int fails = 0;

   // Cache model: contents and tree PLRU per set.
   bit mv [SETS][WAYS];
   bit md [SETS][WAYS];
   int mt [SETS][WAYS];
   bit mp [SETS][WAYS-1];
   int cur_set, cur_tag;

   always #5 clk = ~clk;

   l2_cache_assoc_control #(.WAYS(WAYS), .SETS(SETS)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
      .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write), .way_sel(way_sel),
      .data_write(data_write), .tag_write(tag_write), .valid_in(valid_in), .dirty_in(dirty_in),
      .data_in_sel(data_in_sel), .pmem_addr_sel(pmem_addr_sel)
`ifdef L2_PERF_CNT_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
   );

   function automatic logic [OW-1:0] obs();
      return {mem_resp, pmem_read, pmem_write, way_sel, data_write, tag_write,
              valid_in, dirty_in, data_in_sel, pmem_addr_sel};
   endfunction

   function automatic logic [OW-1:0] ex(bit resp, bit pr, bit pw, logic [WAYS-1:0] ws, bit dw,
                                        bit tw, bit vi, bit di, bit dsel, bit asel);
      return {resp, pr, pw, ws, dw, tw, vi, di, dsel, asel};
   endfunction

   function automatic logic [WAYS-1:0] onehot(int w);
      logic [WAYS-1:0] r;
      r = '0;
      r[w] = 1'b1;
      return r;
   endfunction

   // Victim: first invalid way; otherwise descend the tree halving the way range.
   function automatic int model_victim(int s);
      int node, lo, size, half;
      for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
      node = 0; lo = 0; size = WAYS;
      while (size > 1) begin
         half = size / 2;
         if (!mp[s][node]) node = 2 * node + 1;
         else begin lo += half; node = 2 * node + 2; end
         size = half;
      end
      return lo;
   endfunction

   // Access: every node on the way's range path points to the half not containing it.
   task automatic model_touch(int s, int w);
      int node, lo, size, half;
      node = 0; lo = 0; size = WAYS;
      while (size > 1) begin
         half = size / 2;
         if (w < lo + half) begin mp[s][node] = 1'b1; node = 2 * node + 1; end
         else begin mp[s][node] = 1'b0; lo += half; node = 2 * node + 2; end
         size = half;
      end
   endtask

   function automatic int model_hit(int s, int tag);
      for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == tag) return w;
      return -1;
   endfunction

   task automatic drive_dp();
      for (int w = 0; w < WAYS; w++) begin
         valid_vec[w] = mv[cur_set][w];
         dirty_vec[w] = md[cur_set][w];
         hit_vec[w]   = mv[cur_set][w] && (mt[cur_set][w] == cur_tag);
      end
   endtask

   task automatic clear_model(bit valid, bit dirty, int s);
      for (int w = 0; w < WAYS; w++) begin
         mv[s][w] = valid; md[s][w] = dirty; mt[s][w] = 1000 + w;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int s = 0; s < SETS; s++) for (int n = 0; n < WAYS - 1; n++) mp[s][n] = 1'b0;
   endtask

   // One L1 request from issue to hit, checking every cycle against the model.
   task automatic run_req(input int s, input int tag, input bit wr, input int lat_wb,
                          input int lat_fill, input bit drop, output int cycles,
                          output logic [WAYS-1:0] fill_ws, output logic [WAYS-1:0] hit_ws,
                          output int wb_cyc, output int rd_cyc);
      logic [OW-1:0] o, e;
      int  hw, v;
      bit  wbn, done;
      cycles = 0; wb_cyc = 0; rd_cyc = 0; fill_ws = '0; hit_ws = '0; done = 1'b0;
      for (int pass = 0; pass < 2 && !done; pass++) begin
         @(posedge clk); #1;
         cur_set = s; cur_tag = tag; set_idx = IDX_W'(s);
         mem_write = wr; mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1; pmem_resp = 1'b0;
         drive_dp(); #1; cycles++;
         hw = model_hit(s, tag);
         o = obs();
         if (hw >= 0) begin
            e = ex(1, 0, 0, onehot(hw), wr, 0, 0, wr, 0, 0);
            hit_ws = way_sel;
            tests++;
            if (o !== e) begin fails++; $display("FAIL hit set=%0d tag=%0d: got %b want %b", s, tag, o, e); end
            model_touch(s, hw);
            if (wr) md[s][hw] = 1'b1;
            done = 1'b1;
         end else begin
            e = '0;
            tests++;
            if (o !== e) begin fails++; $display("FAIL miss_detect set=%0d: got %b want %b", s, o, e); end
            v = model_victim(s);
            wbn = mv[s][v] && md[s][v];
            if (wbn) begin
               for (int c = 1; c <= lat_wb; c++) begin
                  @(posedge clk); #1;
                  if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
                  pmem_resp = (c == lat_wb); #1; cycles++;
                  wb_cyc += int'(pmem_write);
                  o = obs(); e = ex(0, 0, 1, onehot(v), 0, 0, 0, 0, 0, 1);
                  tests++;
                  if (o !== e) begin fails++; $display("FAIL write_back c=%0d: got %b want %b", c, o, e); end
               end
            end
            for (int c = 1; c <= lat_fill; c++) begin
               @(posedge clk); #1;
               if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
               pmem_resp = (c == lat_fill); #1; cycles++;
               rd_cyc += int'(pmem_read);
               o = obs();
               if (c == lat_fill) begin
                  e = ex(0, 1, 0, onehot(v), 1, 1, 1, 0, 1, 0);
                  fill_ws = way_sel;
               end else e = ex(0, 1, 0, '0, 0, 0, 0, 0, 0, 0);
               tests++;
               if (o !== e) begin fails++; $display("FAIL fill c=%0d: got %b want %b", c, o, e); end
            end
            mv[s][v] = 1'b1; md[s][v] = 1'b0; mt[s][v] = tag;
            model_touch(s, v);
         end
      end
      // Idle cycle: a stray pmem_resp with no request must produce nothing.
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'($urandom_range(0, 1)); #1;
      o = obs();
      tests++;
      if (o !== '0) begin fails++; $display("FAIL idle: got %b want 0", o); end
   endtask

   task automatic test_reset();
      logic [OW-1:0] o;
      rst = 1'b1; mem_read = 1'b1; hit_vec = 4'b0010; valid_vec = '1;
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      o = obs();
      tests++;
      if (o !== '0) begin fails++; $display("FAIL reset_outs: got %b want 0", o); end
      do_reset();
   endtask

   task automatic test_plru_sequence();
      int cyc, wbc, rdc;
      logic [WAYS-1:0] fws, hws;
      do_reset();
      clear_model(1'b1, 1'b0, 3);
      run_req(3, 100, 1'b0, 2, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      tests++;
      if (fws !== 4'b0001) begin fails++; $display("FAIL plru_first: got %b want 0001", fws); end
      run_req(3, 100, 1'b0, 2, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      run_req(3, 101, 1'b0, 2, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      tests++;
      if (fws !== 4'b0100) begin fails++; $display("FAIL plru_second: got %b want 0100", fws); end
      run_req(3, 101, 1'b0, 2, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      run_req(3, 102, 1'b0, 2, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      tests++;
      if (fws !== 4'b0010) begin fails++; $display("FAIL plru_third: got %b want 0010", fws); end
   endtask

   task automatic test_fill_invalid();
      int cyc, wbc, rdc;
      logic [WAYS-1:0] fws, hws;
      do_reset();
      clear_model(1'b0, 1'b0, 3);
      run_req(3, 7, 1'b0, 3, 3, 1'b0, cyc, fws, hws, wbc, rdc);
      tests++;
      if (fws !== 4'b0001 || wbc !== 0) begin
         fails++; $display("FAIL fill_invalid: got way %b wb %0d want way 0001 wb 0", fws, wbc);
      end
   endtask

   task automatic test_dirty_latency();
      int cyc, wbc, rdc;
      logic [WAYS-1:0] fws, hws;
      do_reset();
      clear_model(1'b1, 1'b1, 5);
      run_req(5, 77, 1'b0, 5, 5, 1'b0, cyc, fws, hws, wbc, rdc);
      tests++;
      if (cyc !== 12 || wbc !== 5 || rdc !== 5) begin
         fails++; $display("FAIL dirty_latency: got resp@%0d wb %0d rd %0d want 12 5 5", cyc, wbc, rdc);
      end
   endtask

   task automatic test_write_hit();
      int cyc, wbc, rdc;
      logic [WAYS-1:0] fws, hws;
      do_reset();
      clear_model(1'b1, 1'b0, 1);
      mt[1][3] = 7;
      run_req(1, 7, 1'b1, 1, 1, 1'b0, cyc, fws, hws, wbc, rdc);
      tests++;
      if (hws !== 4'b1000 || cyc !== 1) begin
         fails++; $display("FAIL write_hit: got way %b cycles %0d want 1000 1", hws, cyc);
      end
   endtask

   task automatic test_reset_mid_wb();
      int cyc, wbc, rdc;
      logic [WAYS-1:0] fws, hws;
      do_reset();
      clear_model(1'b1, 1'b1, 2);
      @(posedge clk); #1;
      cur_set = 2; cur_tag = 50; set_idx = 3'd2; mem_read = 1'b1; drive_dp();
      @(posedge clk); #1;
      tests++;
      if (pmem_write !== 1'b1) begin fails++; $display("FAIL rst_wb_enter: got %b want 1", pmem_write); end
      #2 rst = 1'b1; #1;
      tests++;
      if ({pmem_write, pmem_read} !== 2'b00) begin
         fails++; $display("FAIL rst_wb_drop: got %b want 00", {pmem_write, pmem_read});
      end
      @(posedge clk); #1;
      rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b1; #1;
      tests++;
      if (obs() !== '0) begin fails++; $display("FAIL late_resp: got %b want 0", obs()); end
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      for (int s = 0; s < SETS; s++) for (int n = 0; n < WAYS - 1; n++) mp[s][n] = 1'b0;
      run_req(2, 50, 1'b0, 3, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      tests++;
      if (wbc !== 3 || fws !== 4'b0001) begin
         fails++; $display("FAIL rst_reeval: got wb %0d way %b want 3 0001", wbc, fws);
      end
   endtask

   task automatic test_random();
      int cyc, wbc, rdc;
      logic [WAYS-1:0] fws, hws;
      do_reset();
      for (int s = 0; s < SETS; s++) clear_model(1'b0, 1'b0, s);
      for (int i = 0; i < 150; i++) begin
         run_req(int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)),
                 int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                 cyc, fws, hws, wbc, rdc);
      end
   endtask

`ifdef L2_PERF_CNT_EN
   task automatic test_perf();
      int cyc, wbc, rdc;
      logic [WAYS-1:0] fws, hws;
      do_reset();
      clear_model(1'b1, 1'b0, 4);
      md[4][0] = 1'b1;
      run_req(4, 9, 1'b0, 2, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      run_req(4, 10, 1'b1, 2, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      run_req(4, 9, 1'b0, 2, 2, 1'b0, cyc, fws, hws, wbc, rdc);
      tests++;
      if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2 || wb_cnt !== 32'd1) begin
         fails++; $display("FAIL perf_cnt: got %0d/%0d/%0d want 3/2/1", hit_cnt, miss_cnt, wb_cnt);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_plru_sequence();
      test_fill_invalid();
      test_dirty_latency();
      test_write_hit();
      test_reset_mid_wb();
      test_random();
`ifdef L2_PERF_CNT_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
